// File: rtl/fc_control_gen.sv
// Control sequencer for one fully-connected layer: issues neuron/weight reads, steps the MAC data phase,
// selects the active input lane and strobes accumulator load / output write; hold freezes everything.
module fc_control_gen #(
  parameter int INNEURON      = 64,
  parameter int OUTNEURON     = 20,
  parameter int PI            = 4,
  parameter int PO            = 2,
  parameter int DATA_WIDTH_FC = 16,
  parameter int READ_LAT      = 2,
  parameter int MULT_LAT      = 3,
  localparam int K    = INNEURON / 2,
  localparam int LSEG = K / PI,
  localparam int NGRP = OUTNEURON / PO,
  localparam int CW   = (K > 1) ? $clog2(K) : 1,
  localparam int OW   = $clog2(NGRP + 1),
  localparam int AW   = (LSEG > 1) ? $clog2(LSEG) : 1,
  localparam int WAW  = (K * NGRP > 1) ? $clog2(K * NGRP) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        hold,
  input  logic [DATA_WIDTH_FC*PI-1:0] in_neuron_q_a_all,
  input  logic [DATA_WIDTH_FC*PI-1:0] in_neuron_q_b_all,
  output logic                        in_neuron_rden_a,
  output logic                        in_neuron_rden_b,
  output logic                        in_neuron_wren_a,
  output logic                        in_neuron_wren_b,
  output logic                        fc_weight_rden_a,
  output logic                        fc_weight_rden_b,
  output logic                        fc_weight_wren_a,
  output logic                        fc_weight_wren_b,
  output logic [AW-1:0]               in_addr,
  output logic [WAW-1:0]              weight_addr,
  output logic [DATA_WIDTH_FC-1:0]    in_neuron_q_a_mux,
  output logic [DATA_WIDTH_FC-1:0]    in_neuron_q_b_mux,
  output logic                        accum_sload,
  output logic                        enable_mult,
  output logic                        out_wr_en,
  output logic [CW-1:0]               count_sload,
  output logic [OW-1:0]               count_out,
  output logic                        busy,
  output logic                        done
);

  localparam int PMAX = (READ_LAT > MULT_LAT) ? READ_LAT : MULT_LAT;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PW-1:0]       phase;
  logic                issue_done;
  logic [MULT_LAT-1:0] wr_dly;

  logic        accept;
  logic        issue;
  logic        run_act;
  logic        last_inner;
  logic        last_group;
  logic [31:0] lane;

  assign accept     = (state == S_IDLE) && start;
  assign run_act    = (state == S_RUN) && !hold;
  assign issue      = ((state == S_FILL) || (state == S_RUN)) && !issue_done && !hold;
  assign last_inner = (count_sload == CW'(K - 1));
  assign last_group = (count_out == OW'(NGRP - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL:  if (!hold && phase == PW'(READ_LAT - 1)) state_nxt = S_RUN;
      S_RUN:   if (run_act && last_inner && last_group) state_nxt = S_DRAIN;
      S_DRAIN: if (!hold && phase == PW'(MULT_LAT - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      issue_done  <= 1'b0;
      in_addr     <= '0;
      weight_addr <= '0;
      count_sload <= '0;
      count_out   <= '0;
      wr_dly      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        phase       <= '0;
        issue_done  <= 1'b0;
        in_addr     <= '0;
        weight_addr <= '0;
        count_sload <= '0;
        count_out   <= '0;
        wr_dly      <= '0;
      end else begin
        // Issue side: runs READ_LAT unheld cycles ahead of the data side.
        if (issue) begin
          in_addr <= (in_addr == AW'(LSEG - 1)) ? '0 : in_addr + AW'(1);
          if (weight_addr == WAW'(K * NGRP - 1))
            issue_done <= 1'b1;
          else
            weight_addr <= weight_addr + WAW'(1);
        end

        if (run_act) begin
          if (last_inner) begin
            count_sload <= '0;
            count_out   <= count_out + OW'(1);
          end else begin
            count_sload <= count_sload + CW'(1);
          end
        end

        if (!hold && (state == S_FILL || state == S_DRAIN))
          phase <= (state_nxt != state) ? '0 : phase + PW'(1);

        // Group-end marker travels alongside the multiplier pipeline.
        if (!hold) begin
          wr_dly[0] <= run_act && last_inner;
          for (int i = 1; i < MULT_LAT; i++)
            wr_dly[i] <= wr_dly[i-1];
        end
      end
    end
  end

  always_comb begin
    in_neuron_q_a_mux = '0;
    in_neuron_q_b_mux = '0;
    lane              = 32'(count_sload) / 32'(LSEG);
    if (state == S_RUN) begin
      for (int i = 0; i < PI; i++) begin
        if (lane == 32'(i)) begin
          in_neuron_q_a_mux = in_neuron_q_a_all[i*DATA_WIDTH_FC +: DATA_WIDTH_FC];
          in_neuron_q_b_mux = in_neuron_q_b_all[i*DATA_WIDTH_FC +: DATA_WIDTH_FC];
        end
      end
    end
  end

  assign in_neuron_rden_a = issue;
  assign in_neuron_rden_b = issue;
  assign fc_weight_rden_a = issue;
  assign fc_weight_rden_b = issue;
  assign in_neuron_wren_a = 1'b0;
  assign in_neuron_wren_b = 1'b0;
  assign fc_weight_wren_a = 1'b0;
  assign fc_weight_wren_b = 1'b0;

  assign enable_mult = run_act;
  assign accum_sload = run_act && (count_sload == '0);
  // Gated so a marker parked at the tap during hold yields a single pulse on release.
  assign out_wr_en   = wr_dly[MULT_LAT-1] && !hold;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_fc_control_gen.sv
// Directed bench for fc_control_gen: default layer (K=32, 10 groups) plus a PI=1 single-group instance.
module tb_fc_control_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, hold;
  logic [63:0] qa_all, qb_all;
  logic        rden_a, rden_b, wren_a, wren_b, w_rden_a, w_rden_b, w_wren_a, w_wren_b;
  logic [2:0]  in_addr;
  logic [8:0]  weight_addr;
  logic [15:0] qa_mux, qb_mux;
  logic        sload, en, wr, busy, done;
  logic [4:0]  count_sload;
  logic [3:0]  count_out;

  logic        start1, hold1;
  logic [15:0] qa1, qb1;
  logic        s_rden_a, s_rden_b, s_wren_a, s_wren_b, s_w_rden_a, s_w_rden_b, s_w_wren_a, s_w_wren_b;
  logic [2:0]  s_in_addr, s_weight_addr, s_count_sload;
  logic [15:0] s_qa_mux, s_qb_mux;
  logic        s_sload, s_en, s_wr, s_busy, s_done;
  logic [0:0]  s_count_out;

  int checks = 0;
  int failures = 0;

  fc_control_gen u0 (
    .clock(clock), .reset(reset), .start(start), .hold(hold),
    .in_neuron_q_a_all(qa_all), .in_neuron_q_b_all(qb_all),
    .in_neuron_rden_a(rden_a), .in_neuron_rden_b(rden_b),
    .in_neuron_wren_a(wren_a), .in_neuron_wren_b(wren_b),
    .fc_weight_rden_a(w_rden_a), .fc_weight_rden_b(w_rden_b),
    .fc_weight_wren_a(w_wren_a), .fc_weight_wren_b(w_wren_b),
    .in_addr(in_addr), .weight_addr(weight_addr),
    .in_neuron_q_a_mux(qa_mux), .in_neuron_q_b_mux(qb_mux),
    .accum_sload(sload), .enable_mult(en), .out_wr_en(wr),
    .count_sload(count_sload), .count_out(count_out), .busy(busy), .done(done)
  );

  fc_control_gen #(.INNEURON(16), .OUTNEURON(2), .PI(1), .PO(2)) u1 (
    .clock(clock), .reset(reset), .start(start1), .hold(hold1),
    .in_neuron_q_a_all(qa1), .in_neuron_q_b_all(qb1),
    .in_neuron_rden_a(s_rden_a), .in_neuron_rden_b(s_rden_b),
    .in_neuron_wren_a(s_wren_a), .in_neuron_wren_b(s_wren_b),
    .fc_weight_rden_a(s_w_rden_a), .fc_weight_rden_b(s_w_rden_b),
    .fc_weight_wren_a(s_w_wren_a), .fc_weight_wren_b(s_w_wren_b),
    .in_addr(s_in_addr), .weight_addr(s_weight_addr),
    .in_neuron_q_a_mux(s_qa_mux), .in_neuron_q_b_mux(s_qb_mux),
    .accum_sload(s_sload), .enable_mult(s_en), .out_wr_en(s_wr),
    .count_sload(s_count_sload), .count_out(s_count_out), .busy(s_busy), .done(s_done)
  );

  // Every task starts and ends just after a rising edge; outputs are sampled on the falling edge.
  task automatic to_next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    to_next_cycle();
    @(negedge clock);
    checks++;
    if ({busy, rden_a, rden_b, w_rden_a, w_rden_b, en, sload, wr, done, wren_a, wren_b, w_wren_a, w_wren_b} !== 13'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected all zero",
               {busy, rden_a, rden_b, w_rden_a, w_rden_b, en, sload, wr, done, wren_a, wren_b, w_wren_a, w_wren_b});
    end
    checks++;
    if ({count_sload, count_out, in_addr, weight_addr} !== 21'd0) begin
      failures++;
      $display("FAIL reset_cnt: cs=%0d co=%0d ia=%0d wa=%0d expected 0", count_sload, count_out, in_addr, weight_addr);
    end
    checks++;
    if ({qa_mux, qb_mux} !== 32'd0) begin
      failures++;
      $display("FAIL reset_mux: got %h %h expected 0", qa_mux, qb_mux);
    end
    checks++;
    if ({s_busy, s_rden_a, s_en, s_sload, s_wr, s_done, s_count_out, s_count_sload, s_qa_mux} !== 25'd0) begin
      failures++;
      $display("FAIL reset_small: got %h expected 0", {s_busy, s_rden_a, s_en, s_sload, s_wr, s_done, s_count_out, s_count_sload, s_qa_mux});
    end
    to_next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_full_layer();
    int wr_cnt = 0;
    int done_cnt = 0;
    qa_all = {16'd4, 16'd3, 16'd2, 16'd1};
    qb_all = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    start = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL full_idle_busy: got %b expected 0", busy);
    end
    to_next_cycle();
    start = 1'b0;
    for (int k = 1; k <= 340; k++) begin
      bit exp_rden, exp_en, exp_wr;
      int cs, lane;
      @(negedge clock);
      exp_rden = (k <= 320);
      exp_en   = (k >= 3 && k <= 322);
      exp_wr   = (k >= 37 && k <= 325 && (k - 37) % 32 == 0);
      cs       = (k - 3) % 32;
      lane     = cs / 8;
      if (wr) wr_cnt++;
      if (done) done_cnt++;
      checks++;
      if ({rden_a, rden_b, w_rden_a, w_rden_b} !== {4{exp_rden}}) begin
        failures++;
        $display("FAIL full_rden cycle %0d: got %b expected %b", k, {rden_a, rden_b, w_rden_a, w_rden_b}, {4{exp_rden}});
      end
      checks++;
      if ({en, sload, wr, done, busy} !== {exp_en, exp_en && cs == 0, exp_wr, k == 326, k <= 326}) begin
        failures++;
        $display("FAIL full_strobes cycle %0d: en/sload/wr/done/busy got %b expected %b", k,
                 {en, sload, wr, done, busy}, {exp_en, exp_en && cs == 0, exp_wr, k == 326, k <= 326});
      end
      if (exp_rden) begin
        checks++;
        if (weight_addr !== 9'(k - 1) || in_addr !== 3'((k - 1) % 8)) begin
          failures++;
          $display("FAIL full_addr cycle %0d: wa=%0d ia=%0d expected %0d %0d", k, weight_addr, in_addr, k - 1, (k - 1) % 8);
        end
      end
      if (exp_en) begin
        checks++;
        if (count_sload !== 5'(cs) || count_out !== 4'((k - 3) / 32)) begin
          failures++;
          $display("FAIL full_count cycle %0d: cs=%0d co=%0d expected %0d %0d", k, count_sload, count_out, cs, (k - 3) / 32);
        end
        checks++;
        if (qa_mux !== 16'(lane + 1) || qb_mux !== 16'((lane + 1) * 256)) begin
          failures++;
          $display("FAIL full_mux cycle %0d: got %h %h expected lane %0d", k, qa_mux, qb_mux, lane);
        end
      end else begin
        checks++;
        if ({qa_mux, qb_mux} !== 32'd0) begin
          failures++;
          $display("FAIL full_mux_idle cycle %0d: got %h %h expected 0", k, qa_mux, qb_mux);
        end
      end
      to_next_cycle();
    end
    checks++;
    if (wr_cnt != 10 || done_cnt != 1 || count_out !== 4'd10) begin
      failures++;
      $display("FAIL full_totals: wr=%0d done=%0d co=%0d expected 10 1 10", wr_cnt, done_cnt, count_out);
    end
  endtask

  task automatic test_hold();
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    start = 1'b1;
    to_next_cycle();
    start = 1'b0;
    for (int k = 1; k <= 345; k++) begin
      int u;
      hold = (k >= 16 && k <= 20);
      u = (k < 16) ? k : k - 5;
      @(negedge clock);
      if (wr) wr_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (hold) begin
        checks++;
        if ({en, sload, rden_a, w_rden_a, wr, busy} !== 6'b000001 || count_sload !== 5'd13) begin
          failures++;
          $display("FAIL hold_freeze cycle %0d: en/sload/rden/wrden/wr/busy=%b cs=%0d expected 000001 13", k,
                   {en, sload, rden_a, w_rden_a, wr, busy}, count_sload);
        end
        checks++;
        if (weight_addr !== 9'd15 || in_addr !== 3'd7 || qa_mux !== 16'd2) begin
          failures++;
          $display("FAIL hold_addr cycle %0d: wa=%0d ia=%0d qa=%0d expected 15 7 2", k, weight_addr, in_addr, qa_mux);
        end
      end else begin
        checks++;
        if (en !== (u >= 3 && u <= 322) || wr !== (u >= 37 && u <= 325 && (u - 37) % 32 == 0)) begin
          failures++;
          $display("FAIL hold_strobe cycle %0d: en=%b wr=%b", k, en, wr);
        end
        if (u >= 3 && u <= 322) begin
          checks++;
          if (count_sload !== 5'((u - 3) % 32)) begin
            failures++;
            $display("FAIL hold_count cycle %0d: got %0d expected %0d", k, count_sload, (u - 3) % 32);
          end
        end
      end
      to_next_cycle();
    end
    hold = 1'b0;
    checks++;
    if (wr_cnt != 10 || done_cnt != 1 || done_at != 331) begin
      failures++;
      $display("FAIL hold_totals: wr=%0d done=%0d at %0d expected 10 1 331", wr_cnt, done_cnt, done_at);
    end
  endtask

  task automatic test_reset_mid();
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    start = 1'b1;
    to_next_cycle();
    start = 1'b0;
    for (int k = 1; k <= 136; k++) begin
      reset = (k == 136);
      @(negedge clock);
      if (k == 135) begin
        checks++;
        if (count_out !== 4'd4 || en !== 1'b1) begin
          failures++;
          $display("FAIL mid_pre: co=%0d en=%b expected 4 1", count_out, en);
        end
      end
      to_next_cycle();
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, rden_a, w_rden_a, en, sload, wr, done} !== 7'd0 ||
        {count_sload, count_out, in_addr, weight_addr, qa_mux} !== 37'd0) begin
      failures++;
      $display("FAIL mid_reset: ctrl=%b cs=%0d co=%0d ia=%0d wa=%0d qa=%h expected 0",
               {busy, rden_a, w_rden_a, en, sload, wr, done}, count_sload, count_out, in_addr, weight_addr, qa_mux);
    end
    to_next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done || busy) done_cnt++;
      to_next_cycle();
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL mid_no_done: got %0d busy/done cycles expected 0", done_cnt);
    end
    start = 1'b1;
    to_next_cycle();
    start = 1'b0;
    for (int k = 1; k <= 340; k++) begin
      @(negedge clock);
      if (wr) wr_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      to_next_cycle();
    end
    checks++;
    if (wr_cnt != 10 || done_cnt != 1 || done_at != 326 || count_out !== 4'd10) begin
      failures++;
      $display("FAIL mid_restart: wr=%0d done=%0d at %0d co=%0d expected 10 1 326 10", wr_cnt, done_cnt, done_at, count_out);
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    int done_at = -1;
    start = 1'b1;
    hold  = 1'b1;
    to_next_cycle();
    hold = 1'b0;
    for (int k = 1; k <= 360; k++) begin
      start = (k == 50 || k == 326);
      @(negedge clock);
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1 || rden_a !== 1'b1) begin
          failures++;
          $display("FAIL ign_idle_hold: busy=%b rden=%b expected 1 1", busy, rden_a);
        end
      end
      if (k == 327 || k == 360) begin
        checks++;
        if (busy !== 1'b0 || rden_a !== 1'b0) begin
          failures++;
          $display("FAIL ign_after_done cycle %0d: busy=%b rden=%b expected 0 0", k, busy, rden_a);
        end
      end
      to_next_cycle();
    end
    start = 1'b0;
    checks++;
    if (done_cnt != 1 || done_at != 326) begin
      failures++;
      $display("FAIL ign_done: got %0d pulses at %0d expected 1 at 326", done_cnt, done_at);
    end
  endtask

  task automatic test_small();
    int wr_cnt = 0;
    qa1 = 16'hABCD;
    qb1 = 16'h1234;
    start1 = 1'b1;
    to_next_cycle();
    start1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      bit exp_en;
      exp_en = (k >= 3 && k <= 10);
      @(negedge clock);
      if (s_wr) wr_cnt++;
      checks++;
      if ({s_rden_a, s_w_rden_b, s_en, s_sload, s_wr, s_done, s_busy} !==
          {k <= 8, k <= 8, exp_en, k == 3, k == 13, k == 14, k <= 14}) begin
        failures++;
        $display("FAIL small_strobes cycle %0d: got %b expected %b", k,
                 {s_rden_a, s_w_rden_b, s_en, s_sload, s_wr, s_done, s_busy},
                 {k <= 8, k <= 8, exp_en, k == 3, k == 13, k == 14, k <= 14});
      end
      if (k <= 8) begin
        checks++;
        if (s_in_addr !== 3'(k - 1) || s_weight_addr !== 3'(k - 1)) begin
          failures++;
          $display("FAIL small_addr cycle %0d: ia=%0d wa=%0d expected %0d", k, s_in_addr, s_weight_addr, k - 1);
        end
      end
      checks++;
      if (exp_en ? (s_qa_mux !== 16'hABCD || s_qb_mux !== 16'h1234 || s_count_sload !== 3'(k - 3))
                 : ({s_qa_mux, s_qb_mux} !== 32'd0)) begin
        failures++;
        $display("FAIL small_mux cycle %0d: qa=%h qb=%h cs=%0d", k, s_qa_mux, s_qb_mux, s_count_sload);
      end
      to_next_cycle();
    end
    checks++;
    if (wr_cnt != 1 || s_count_out !== 1'b1) begin
      failures++;
      $display("FAIL small_totals: wr=%0d co=%0d expected 1 1", wr_cnt, s_count_out);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    hold   = 1'b0;
    start1 = 1'b0;
    hold1  = 1'b0;
    qa_all = '0;
    qb_all = '0;
    qa1    = '0;
    qb1    = '0;
    to_next_cycle();
    test_reset();
    test_full_layer();
    test_hold();
    test_reset_mid();
    test_start_ignored();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
